// File: rtl/gate_out_monitor.sv
// -----------------------------------------------------------------------------
// gate_out_monitor
//
// Watches the output of a two-input AND gate. The gate output is brought into
// the clk domain, its rising and falling edges are counted, each high pulse is
// measured, and every completed pulse length is offered to a consumer over a
// valid/ready report interface. A long high level raises stuck_hi.
//
// Ports
//   clk        : clock, all state on its rising edge
//   rst_n      : asynchronous active-low reset
//   c_in       : AND gate output, may be asynchronous to clk
//   clear      : synchronous clear of edge counters, report and ovf
//   level      : synchronized c_in
//   rise_cnt   : saturating count of rising edges
//   fall_cnt   : saturating count of falling edges
//   rpt_valid  : a pulse-length report is pending
//   rpt_ready  : consumer accepts the pending report
//   rpt_len    : length in cycles of the reported high pulse (saturating)
//   ovf        : sticky, a pulse completed while a report was still pending
//   stuck_hi   : level has been high for at least HOLD_MAX cycles
// -----------------------------------------------------------------------------
module gate_out_monitor #(
    parameter int CNT_W    = 8,
    parameter int LEN_W    = 8,
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             c_in,
    input  logic             clear,
    output logic             level,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] fall_cnt,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [LEN_W-1:0] rpt_len,
    output logic             ovf,
    output logic             stuck_hi
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] HOLD_L  = LEN_W'(HOLD_MAX);

    typedef enum logic [1:0] {
        ST_LOW   = 2'd0,
        ST_HIGH  = 2'd1,
        ST_STUCK = 2'd2
    } state_t;

    // Synchronizer and edge history
    logic             sync1_q;
    logic             level_q;
    logic             prev_q;

    logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
    logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d;
    logic [LEN_W-1:0] run_q,      run_d;
    state_t           state_q,    state_d;
    logic             rpt_valid_q, rpt_valid_d;
    logic [LEN_W-1:0] rpt_len_q,   rpt_len_d;
    logic             ovf_q,       ovf_d;

    logic rise;
    logic fall;

    assign rise = level_q & ~prev_q;
    assign fall = ~level_q & prev_q;

    // Run counter: value seen in the fall cycle equals the number of cycles
    // level was high, because it loads 1 on the rise cycle itself.
    always_comb begin
        run_d = run_q;
        if (rise) begin
            run_d = LEN_W'(1);
        end else if (level_q && (run_q != LEN_MAX)) begin
            run_d = run_q + LEN_W'(1);
        end
    end

    // Pulse-state FSM. The HOLD_MAX threshold is tested against run_d so that
    // stuck_hi becomes visible on the same edge the run count reaches it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOW: begin
                if (rise) begin
                    state_d = (run_d >= HOLD_L) ? ST_STUCK : ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    state_d = ST_LOW;
                end else if (level_q && (run_d >= HOLD_L)) begin
                    state_d = ST_STUCK;
                end
            end
            ST_STUCK: begin
                if (fall) begin
                    state_d = ST_LOW;
                end
            end
            default: state_d = ST_LOW;
        endcase
    end

    // Edge counters, report register and overflow flag. clear wins over an
    // edge in the same cycle, so that edge is neither counted nor reported.
    always_comb begin
        rise_cnt_d  = rise_cnt_q;
        fall_cnt_d  = fall_cnt_q;
        rpt_valid_d = rpt_valid_q;
        rpt_len_d   = rpt_len_q;
        ovf_d       = ovf_q;

        if (rise && (rise_cnt_q != CNT_MAX)) begin
            rise_cnt_d = rise_cnt_q + CNT_W'(1);
        end
        if (fall && (fall_cnt_q != CNT_MAX)) begin
            fall_cnt_d = fall_cnt_q + CNT_W'(1);
        end

        if (rpt_valid_q && rpt_ready) begin
            rpt_valid_d = 1'b0;
        end

        if (fall) begin
            if (!rpt_valid_q || rpt_ready) begin
                rpt_len_d   = run_q;
                rpt_valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (clear) begin
            rise_cnt_d  = '0;
            fall_cnt_d  = '0;
            rpt_valid_d = 1'b0;
            rpt_len_d   = '0;
            ovf_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            level_q     <= 1'b0;
            prev_q      <= 1'b0;
            rise_cnt_q  <= '0;
            fall_cnt_q  <= '0;
            run_q       <= '0;
            state_q     <= ST_LOW;
            rpt_valid_q <= 1'b0;
            rpt_len_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            sync1_q     <= c_in;
            level_q     <= sync1_q;
            prev_q      <= level_q;
            rise_cnt_q  <= rise_cnt_d;
            fall_cnt_q  <= fall_cnt_d;
            run_q       <= run_d;
            state_q     <= state_d;
            rpt_valid_q <= rpt_valid_d;
            rpt_len_q   <= rpt_len_d;
            ovf_q       <= ovf_d;
        end
    end

    assign level     = level_q;
    assign rise_cnt  = rise_cnt_q;
    assign fall_cnt  = fall_cnt_q;
    assign rpt_valid = rpt_valid_q;
    assign rpt_len   = rpt_len_q;
    assign ovf       = ovf_q;
    assign stuck_hi  = (state_q == ST_STUCK);

endmodule

// File: tb/tb_gate_out_monitor.sv
// Bench for gate_out_monitor: directed scenarios with literal expectations,
// then randomized gate activity compared every cycle against a pulse-level
// reference model.
module tb_gate_out_monitor;

    localparam int CNT_W    = 8;
    localparam int LEN_W    = 8;
    localparam int HOLD_MAX = 16;
    localparam int CMAX     = (1 << CNT_W) - 1;
    localparam int LMAX     = (1 << LEN_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             c_in;
    logic             clear;
    logic             level;
    logic [CNT_W-1:0] rise_cnt;
    logic [CNT_W-1:0] fall_cnt;
    logic             rpt_valid;
    logic             rpt_ready;
    logic [LEN_W-1:0] rpt_len;
    logic             ovf;
    logic             stuck_hi;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 0;

    gate_out_monitor #(.CNT_W(CNT_W), .LEN_W(LEN_W), .HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .c_in(c_in), .clear(clear),
        .level(level), .rise_cnt(rise_cnt), .fall_cnt(fall_cnt),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_len(rpt_len),
        .ovf(ovf), .stuck_hi(stuck_hi)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Tracks the sampled pipeline of c_in, the number of completed high
    // cycles of the current pulse (unbounded integer), and the bookkeeping
    // of rises, falls and reports. Saturation is applied only when outputs
    // are predicted.
    bit m_s1, m_lvl, m_prev;
    int m_hi;          // completed high cycles in the current pulse
    int m_rises, m_falls;
    bit m_v, m_ovf, m_stuck;
    int m_len;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 0; m_lvl = 0; m_prev = 0; m_hi = 0;
            m_rises = 0; m_falls = 0; m_v = 0; m_ovf = 0; m_stuck = 0; m_len = 0;
        end else begin
            bit r, f;
            int pulse;
            r = m_lvl && !m_prev;
            f = !m_lvl && m_prev;
            pulse = m_hi;                       // length of the pulse just ended
            if (r) m_hi = 1;
            else if (m_lvl) m_hi = m_hi + 1;
            m_stuck = m_lvl && !f && (m_hi >= HOLD_MAX);
            if (clear) begin
                m_rises = 0; m_falls = 0; m_v = 0; m_len = 0; m_ovf = 0;
            end else begin
                bit accepted;
                accepted = m_v && rpt_ready;
                if (r) m_rises++;
                if (f) m_falls++;
                if (accepted) m_v = 0;
                if (f) begin
                    if (!m_v) begin
                        m_v = 1;
                        m_len = (pulse > LMAX) ? LMAX : pulse;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
            m_prev = m_lvl; m_lvl = m_s1; m_s1 = c_in;
        end
    end

    function automatic int satc(int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [31:0] exp_v, act_v;
            exp_v = {m_lvl, CNT_W'(satc(m_rises)), CNT_W'(satc(m_falls)), m_v,
                     LEN_W'(m_len), m_ovf, m_stuck};
            act_v = {level, rise_cnt, fall_cnt, rpt_valid, rpt_len, ovf, stuck_hi};
            n_tests++;
            if (exp_v !== act_v) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t act lvl=%0b r=%0d f=%0d v=%0b len=%0d ovf=%0b st=%0b req lvl=%0b r=%0d f=%0d v=%0b len=%0d ovf=%0b st=%0b",
                         $time, level, rise_cnt, fall_cnt, rpt_valid, rpt_len, ovf, stuck_hi,
                         m_lvl, satc(m_rises), satc(m_falls), m_v, m_len, m_ovf, m_stuck);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s act=%0d req=%0d", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    int vcount, lenseen, stcount, hibefore;
    bit stseen;

    initial begin
        rst_n = 0; c_in = 0; clear = 0; rpt_ready = 0;
        cyc(3);
        rst_n = 1;
        cmp_en = 1;

        // 1: idle after reset
        cyc(10);
        at_neg();
        chk("idle_outputs", {level, rise_cnt, fall_cnt, rpt_valid, rpt_len, ovf, stuck_hi}, 0);

        // 2: single 5-cycle pulse, consumer ready
        rpt_ready = 1;
        cyc(1);
        c_in = 1;
        vcount = 0; lenseen = -1;
        cyc(5);
        c_in = 0;
        repeat (8) begin
            at_neg();
            if (rpt_valid) begin vcount++; lenseen = rpt_len; end
        end
        chk("p5_rise_cnt", rise_cnt, 1);
        chk("p5_fall_cnt", fall_cnt, 1);
        chk("p5_valid_cycles", vcount, 1);
        chk("p5_len", lenseen, 5);
        chk("p5_ovf", ovf, 0);

        // 3: two pulses with consumer stalled
        cyc(1);
        rpt_ready = 0;
        c_in = 1; cyc(3); c_in = 0; cyc(3);
        c_in = 1; cyc(4); c_in = 0; cyc(5);
        at_neg();
        chk("stall_valid", rpt_valid, 1);
        chk("stall_len", rpt_len, 3);
        chk("stall_ovf", ovf, 1);
        cyc(1);
        rpt_ready = 1;
        cyc(1);
        rpt_ready = 0;
        at_neg();
        chk("stall_drain_valid", rpt_valid, 0);
        chk("stall_ovf_sticky", ovf, 1);

        // 5: clear coincides with the rise cycle, counters at 3/3
        chk("pre_clear_rise", rise_cnt, 3);
        cyc(1);
        c_in = 1;
        cyc(2);             // level just went high: this is the rise cycle
        clear = 1;
        cyc(1);
        clear = 0;
        at_neg();
        chk("clr_rise_cnt", rise_cnt, 0);
        chk("clr_fall_cnt", fall_cnt, 0);
        chk("clr_ovf", ovf, 0);
        cyc(2);
        c_in = 0;
        cyc(4);
        at_neg();
        chk("clr_fall_after", fall_cnt, 1);
        chk("clr_report", rpt_valid, 1);
        chk("clr_rise_after", rise_cnt, 0);

        // 4: 20-cycle pulse exercises stuck_hi
        cyc(1);
        rpt_ready = 1;
        cyc(2);
        c_in = 1;
        stcount = 0; hibefore = 0; stseen = 0; lenseen = -1;
        fork
            begin
                cyc(20);
                c_in = 0;
            end
            begin
                repeat (30) begin
                    at_neg();
                    if (stuck_hi) begin stcount++; stseen = 1; end
                    else if (level && !stseen) hibefore++;
                    if (rpt_valid) lenseen = rpt_len;
                end
            end
        join
        chk("stuck_high_cycles_before", hibefore, HOLD_MAX);
        chk("stuck_cycles", stcount, 5);
        chk("stuck_len", lenseen, 20);
        chk("stuck_cleared", stuck_hi, 0);

        // 6: reset mid-pulse with c_in held high
        rpt_ready = 0;
        cyc(1);
        c_in = 1;
        cyc(6);
        rst_n = 0;
        #1;
        chk("rst_outputs", {level, rise_cnt, fall_cnt, rpt_valid, rpt_len, ovf, stuck_hi}, 0);
        cyc(2);
        rst_n = 1;
        cyc(6);
        at_neg();
        chk("rst_rise_cnt", rise_cnt, 1);
        chk("rst_no_report", rpt_valid, 0);
        cyc(1);
        c_in = 0;
        cyc(4);
        at_neg();
        chk("rst_report_after_fall", rpt_valid, 1);
        chk("rst_fall_cnt", fall_cnt, 1);

        // random traffic: mixed pulse lengths, stalls, clears, resets
        cyc(1);
        for (int seg = 0; seg < 300; seg++) begin
            int len;
            c_in = ~c_in;
            len = ($urandom_range(0, 19) == 0) ? $urandom_range(200, 300)
                                               : $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                rpt_ready = $urandom_range(0, 1);
                clear = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 599) == 0) rst_n = 0;
                cyc(1);
                rst_n = 1;
            end
        end
        clear = 0; rpt_ready = 1;

        // fast toggling drives the edge counters into saturation
        for (int k = 0; k < 1200; k++) begin
            if (k % 2 == 0) c_in = ~c_in;
            cyc(1);
        end
        cyc(4);
        at_neg();
        chk("rise_saturated", rise_cnt, CMAX);
        chk("fall_saturated", fall_cnt, CMAX);

        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_out_monitor.md
Name: gate_out_monitor

Overview:
- Downstream consumer of the two-input AND gate output `c`.
- Samples the gate output into the clock domain and counts its rising and falling edges.
- Measures the length of each high pulse and flags a stuck-high condition.
- Hands each completed pulse measurement to a host or checker over a valid/ready report interface.

Parameters:
- CNT_W, 8: width of the rise and fall edge counters (saturating).
- LEN_W, 8: width of the pulse-length measurement (saturating).
- HOLD_MAX, 16: number of consecutive high sampled cycles after which stuck_hi asserts (1 ≤ HOLD_MAX < 2^LEN_W).

Ports:
- clk, input, 1: single clock; all state is on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- c_in, input, 1: AND gate output; may be asynchronous to clk.
- clear, input, 1: synchronous clear of counters, report and ovf.
- level, output, 1: synchronized c_in.
- rise_cnt, output, CNT_W: number of rising edges seen.
- fall_cnt, output, CNT_W: number of falling edges seen.
- rpt_valid, output, 1: a report is pending.
- rpt_ready, input, 1: consumer accepts the report.
- rpt_len, output, LEN_W: length in cycles of the reported high pulse.
- ovf, output, 1: sticky flag; a pulse completed while a report was still pending.
- stuck_hi, output, 1: level has been high for at least HOLD_MAX cycles.

Behaviour:
- **Reset (rst_n low, asynchronous):**
  - Synchronizer flops, prev, state, run counter and all outputs go to 0.
  - On release, the first edge decision needs two sampled cycles.
- **Synchronizer:**
  - sync1 <= c_in; level <= sync1; prev <= level.
  - rise = level & ~prev; fall = ~level & prev.
  - If c_in changes before edge E0, level changes after E1.
  - The corresponding counter updates at E2.
- **Edge counters:**
  - rise_cnt increments on rise; fall_cnt increments on fall.
  - Both saturate at 2^CNT_W-1 and never wrap.
- **Run counter (LEN_W bits, saturating):**
  - Loads 1 on the rise cycle.
  - Increments each cycle while level stays high.
  - Holds while low.
  - Its value when fall is seen equals the number of cycles level was high.
- **State machine: LOW, HIGH, STUCK.**
  - LOW -> HIGH on rise.
  - HIGH -> STUCK when the run counter reaches HOLD_MAX; stuck_hi = 1 exactly while in STUCK.
  - HIGH or STUCK -> LOW on fall.
  - Leaving STUCK deasserts stuck_hi on the same edge that registers the fall.
- **Report on fall:**
  - If rpt_valid = 0, or rpt_valid = 1 and rpt_ready = 1: load rpt_len with the run count and set rpt_valid = 1.
  - If rpt_valid = 1 and rpt_ready = 0: keep the old report unchanged and set ovf = 1 (sticky).
- **Handshake:**
  - rpt_len is stable while rpt_valid = 1.
  - The transfer completes at an edge where rpt_valid and rpt_ready are both 1; rpt_valid drops next cycle unless a fall reloads it on that same edge.
  - rpt_ready while rpt_valid = 0 is ignored.
- **clear:**
  - Zeroes rise_cnt, fall_cnt, rpt_valid, rpt_len and ovf.
  - Has priority over an edge arriving in the same cycle; that edge is not counted and not reported.
  - Does not touch the synchronizer, prev, state, run counter or stuck_hi.
- **Boundary cases:**
  - A glitch on c_in shorter than one clock period may be missed; this is not an error.
  - A run longer than 2^LEN_W-1 cycles reports 2^LEN_W-1.
  - Reset mid-pulse discards the pulse, and no report is generated after reset.

Test Plan:
1. Reset, then c_in = 0 for 10 cycles -> all outputs 0; state LOW.
2. c_in high for 5 cycles then low, rpt_ready = 1 -> level rises 2 edges after c_in; rise_cnt = 1; fall_cnt = 1; one rpt_valid cycle with rpt_len = 5; ovf = 0.
3. Two pulses of lengths 3 and 4 with rpt_ready = 0 -> rpt_valid stays high with rpt_len = 3; ovf = 1 after the second fall. Then rpt_ready = 1 for one cycle -> rpt_valid drops.
4. HOLD_MAX = 16, c_in high for 20 cycles -> stuck_hi rises when the run count reaches 16 and falls with the registered fall; rpt_len = 20.
5. clear asserted in the same cycle as a rise, with counters at 3/3 -> rise_cnt = 0 afterwards; the subsequent fall gives fall_cnt = 1 and a valid report.
6. rst_n pulsed low mid-pulse, with c_in held high throughout -> outputs go to 0 immediately. After release: rise_cnt = 1, and no report until the next fall.
